// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control inputs, instruction-memory handshake and IF output.
// No storage; pure signal grouping, zero latency.
// Backpressure is carried by if_ready (downstream) and imem_ack (memory) inside the bundle.
interface fetch_stage_if #(
   parameter int width = 32
);
   logic             pc_src;
   logic [width-1:0] branch_target;
   logic             stall;
   logic             flush;
   logic             imem_req;
   logic [width-1:0] imem_addr;
   logic             imem_ack;
   logic [width-1:0] imem_rdata;
   logic             if_valid;
   logic             if_ready;
   logic [width-1:0] if_pc;
   logic [width-1:0] if_instr;

   // Fetch stage side
   modport master (
      input  pc_src, branch_target, stall, flush, imem_ack, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_pc, if_instr
   );

   // Pipeline control / memory / decode side
   modport slave (
      output pc_src, branch_target, stall, flush, imem_ack, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request per slot, registers the returned word.
// Latency: 1 cycle from request (0-wait ack) to if_valid; one instruction per 2 cycles sustained.
// Backpressure: a held output (if_valid & !if_ready) or stall blocks new requests; an issued request stays up until ack.
module fetch_stage #(
   parameter int               width    = 32,
   parameter logic [width-1:0] reset_pc = '0
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master fetch_bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_req;
   logic [width-1:0] r_pc;
   logic             r_if_valid;
   logic [width-1:0] r_if_pc;
   logic [width-1:0] r_if_instr;

   logic             w_ack;
   logic             w_slot_free;
   logic             w_consume;
   logic [width-1:0] w_next_pc;

   // ack is only meaningful while a request is outstanding
   assign w_ack       = fetch_bus.imem_ack & r_req;
   assign w_slot_free = !r_if_valid || fetch_bus.if_ready;
   assign w_consume   = r_if_valid && fetch_bus.if_ready;
   assign w_next_pc   = fetch_bus.pc_src ? fetch_bus.branch_target : (r_pc + width'(4));

   assign fetch_bus.imem_req  = r_req;
   assign fetch_bus.imem_addr = r_pc;
   assign fetch_bus.if_valid  = r_if_valid;
   assign fetch_bus.if_pc     = r_if_pc;
   assign fetch_bus.if_instr  = r_if_instr;

   // FSM, PC and output register; flush overrides ack, stall and if_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_pc       <= reset_pc;
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= '0;
      end else if (fetch_bus.flush) begin
         r_pc       <= fetch_bus.branch_target;
         r_if_valid <= 1'b0;
         if (r_state != S_IDLE) begin
            // an unanswered request must still be drained, its data is dead
            if (w_ack) begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end else begin
               r_state <= S_DROP;
               r_req   <= 1'b1;
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_consume) r_if_valid <= 1'b0;
               if (!fetch_bus.stall && w_slot_free) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
               end
            end
            S_REQ: begin
               if (w_ack) begin
                  r_if_instr <= fetch_bus.imem_rdata;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_pc       <= w_next_pc;
                  r_state    <= S_IDLE;
                  r_req      <= 1'b0;
               end else if (w_consume) begin
                  r_if_valid <= 1'b0;
               end
            end
            S_DROP: begin
               if (w_consume) r_if_valid <= 1'b0;
               if (w_ack) begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule
